mux_operand_feeder: RTL and testbench

- Upstream operand stage for the 2:1 selector block (`test5`: inputs A, D[1:0]; output Y = A ? D[1] : D[0]).
- Buffers (sel, data) operand pairs in a small FIFO and drives them into the selector's A/D inputs, one per cycle.
- Samples the selector's Y back each cycle and packs the results into a RES_W-bit word; pulses res_valid when the word is complete.

---
 rtl/mux_operand_feeder.sv | 173 +++++++++++++++++
 tb/tb_mux_operand_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_operand_feeder.sv
// mux_operand_feeder
//   Operand stage that feeds a 2:1 selector (Y = A ? D[1] : D[0]).
//   Buffers (sel, data) pairs in a DEPTH-entry FIFO. It pops one pair per
//   cycle into the registered mux_a/mux_d drives and samples the selector's
//   mux_y back at the following edge. Samples are packed MSB-first (oldest
//   result in the MSB) into an RES_W-bit word. When the word is full,
//   res_valid pulses for one cycle.
//
// Optional build macro: MUX_FEEDER_SELF_CHECK_EN
//   Defined   : mux_y is compared against the locally recomputed selector
//               result while driving; any mismatch sets the sticky err flag.
//   Undefined : no comparator; err is tied low.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair offered
//   in_ready   FIFO can accept (!full)
//   in_sel     select bit, later driven on mux_a
//   in_data    data pair, later driven on mux_d
//   mux_a      registered selector A drive
//   mux_d      registered selector D[1:0] drive
//   mux_y      selector output Y (combinational from mux_a/mux_d)
//   res_bits   packed results, oldest in MSB
//   res_valid  one-cycle pulse; res_bits is complete in that cycle
//   res_count  results captured into the current word
//   busy       state != IDLE or FIFO non-empty
//   err        sticky self-check mismatch flag
module mux_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int RES_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sel,
  input  logic [1:0]                 in_data,
  output logic                       mux_a,
  output logic [1:0]                 mux_d,
  input  logic                       mux_y,
  output logic [RES_W-1:0]           res_bits,
  output logic                       res_valid,
  output logic [$clog2(RES_W+1)-1:0] res_count,
  output logic                       busy,
  output logic                       err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RCW = $clog2(RES_W + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t state, state_next;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;
  logic [2:0]    head;
  logic [RCW-1:0] res_count_inc;
  logic           word_done;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  // in_ready depends only on full, so a push is refused when the FIFO is
  // full even if a pop happens in the same cycle.
  assign push          = in_valid && !full;
  assign head          = mem[rd_ptr];
  assign res_count_inc = res_count + RCW'(1);
  assign word_done     = (state == DRIVE) && (res_count_inc == RCW'(RES_W));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and pop decision. DONE pops like IDLE in its exit edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      DRIVE: begin
        if (word_done) begin
          state_next = DONE;
        end else if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from state and occupancy
  always_comb begin
    res_valid = (state == DONE);
    busy      = (state != IDLE) || !empty;
    in_ready  = !full;
  end

  // FIFO storage (no reset needed; occupancy gates every read)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sel, in_data};
  end

  // FIFO pointers, occupancy, selector drives, result packing
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mux_a     <= 1'b0;
      mux_d     <= '0;
      res_bits  <= '0;
      res_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        mux_a  <= head[2];
        mux_d  <= head[1:0];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case (state)
        DRIVE: begin
          res_bits  <= {res_bits[RES_W-2:0], mux_y};
          res_count <= res_count_inc;
        end
        DONE: begin
          res_bits  <= '0;
          res_count <= '0;
        end
        default: begin
          res_bits  <= res_bits;
          res_count <= res_count;
        end
      endcase
    end
  end

`ifdef MUX_FEEDER_SELF_CHECK_EN
  logic expected_y;
  assign expected_y = mux_a ? mux_d[1] : mux_d[0];

  always_ff @(posedge clk) begin
    if (rst)                                       err <= 1'b0;
    else if (state == DRIVE && mux_y != expected_y) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_operand_feeder.sv
module tb_mux_operand_feeder;

  localparam int DEPTH = 4;
  localparam int RES_W = 8;
`ifdef MUX_FEEDER_SELF_CHECK_EN
  localparam logic SELF_CHECK = 1'b1;
`else
  localparam logic SELF_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sel = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       mux_a;
  logic [1:0] mux_d;
  logic       mux_y;
  logic [7:0] res_bits;
  logic       res_valid;
  logic [3:0] res_count;
  logic       busy;
  logic       err;
  logic       force_y0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Selector model: Y = A ? D[1] : D[0], optionally forced low
  assign mux_y = force_y0 ? 1'b0 : (mux_a ? mux_d[1] : mux_d[0]);

  mux_operand_feeder #(.DEPTH(DEPTH), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .mux_a(mux_a), .mux_d(mux_d),
    .mux_y(mux_y), .res_bits(res_bits), .res_valid(res_valid),
    .res_count(res_count), .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, vld, sel;
    logic [1:0] data;
    logic [7:0] e_bits;
    logic [3:0] e_cnt;
    logic       e_rv, e_rdy, e_busy, e_a;
    logic [1:0] e_d;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, v, s, input logic [1:0] d, input logic [7:0] eb,
                     input logic [3:0] ec, input logic erv, erdy, ebusy, ea,
                     input logic [1:0] ed);
    vec_t t;
    t = '{rst: r, vld: v, sel: s, data: d, e_bits: eb, e_cnt: ec, e_rv: erv,
          e_rdy: erdy, e_busy: ebusy, e_a: ea, e_d: ed};
    vq.push_back(t);
  endtask

  // Fill-test monitors
  logic     track = 1'b0;
  logic     acc_y[$];
  logic [7:0] words[$];
  int       drops = 0;

  always @(posedge clk) begin
    if (track && in_valid) begin
      if (in_ready) acc_y.push_back(in_sel ? in_data[1] : in_data[0]);
      else          drops++;
    end
  end

  always @(negedge clk) begin
    if (track && res_valid) words.push_back(res_bits);
  end

  initial begin
    // ---- table: reset, back-to-back pair, full word ----
    add(1,0,0,2'b00, 8'h00,0,0,1,0,0,2'b00);
    add(1,0,0,2'b00, 8'h00,0,0,1,0,0,2'b00);
    add(0,1,0,2'b01, 8'h00,0,0,1,1,0,2'b00);
    add(0,1,1,2'b10, 8'h00,0,0,1,1,0,2'b01);
    add(0,0,0,2'b00, 8'h01,1,0,1,1,1,2'b10);
    add(0,0,0,2'b00, 8'h03,2,0,1,0,1,2'b10);
    add(1,0,0,2'b00, 8'h00,0,0,1,0,0,2'b00);
    add(0,1,0,2'b01, 8'h00,0,0,1,1,0,2'b00);
    add(0,1,0,2'b10, 8'h00,0,0,1,1,0,2'b01);
    add(0,1,0,2'b01, 8'h01,1,0,1,1,0,2'b10);
    add(0,1,0,2'b10, 8'h02,2,0,1,1,0,2'b01);
    add(0,1,0,2'b01, 8'h05,3,0,1,1,0,2'b10);
    add(0,1,0,2'b10, 8'h0A,4,0,1,1,0,2'b01);
    add(0,1,0,2'b01, 8'h15,5,0,1,1,0,2'b10);
    add(0,1,0,2'b10, 8'h2A,6,0,1,1,0,2'b01);
    add(0,0,0,2'b00, 8'h55,7,0,1,1,0,2'b10);
    add(0,0,0,2'b00, 8'hAA,8,1,1,1,0,2'b10);
    add(0,0,0,2'b00, 8'h00,0,0,1,0,0,2'b10);

    @(negedge clk);
    foreach (vq[i]) begin
      rst = vq[i].rst; in_valid = vq[i].vld; in_sel = vq[i].sel; in_data = vq[i].data;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d res_bits", i), 32'(res_bits), 32'(vq[i].e_bits));
      chk($sformatf("v%0d res_count", i), 32'(res_count), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(vq[i].e_rv));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("v%0d mux_a", i), 32'(mux_a), 32'(vq[i].e_a));
      chk($sformatf("v%0d mux_d", i), 32'(mux_d), 32'(vq[i].e_d));
      chk($sformatf("v%0d err", i), 32'(err), 32'(1'b0));
    end
    in_valid = 1'b0;

    // ---- fill: continuous offers, FIFO grows by one per completed word ----
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    track = 1'b1;
    for (int i = 0; i < 48; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      in_valid = 1'b1;
      in_sel   = iv[0];
      in_data  = {iv[1] ^ iv[3], iv[2]};
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    begin
      int c;
      c = 0;
      while (busy && c < 80) begin
        @(posedge clk); @(negedge clk); c++;
      end
      chk("fill_drain_busy", 32'(busy), 32'(0));
    end
    track = 1'b0;
    chk("fill_drop_seen", 32'(drops != 0), 32'(1));
    chk("fill_accept_count", 32'(acc_y.size() + drops), 32'(48));
    chk("fill_word_count", 32'(words.size()), 32'(acc_y.size() / RES_W));
    for (int w = 0; w < words.size() && w < acc_y.size() / RES_W; w++) begin
      logic [7:0] exp_w;
      exp_w = '0;
      for (int b = 0; b < RES_W; b++) exp_w = {exp_w[6:0], acc_y[w*RES_W + b]};
      chk($sformatf("fill_word%0d", w), 32'(words[w]), 32'(exp_w));
    end

    // ---- reset in the middle of the second word ----
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    begin
      logic seen_rv, hit;
      int bad;
      seen_rv = 1'b0; hit = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (res_valid) seen_rv = 1'b1;
        if (seen_rv && res_count == 4'd5) begin
          hit = 1'b1;
          break;
        end
        in_valid = 1'b1; in_sel = 1'b1; in_data = 2'b11;
        @(posedge clk); @(negedge clk);
      end
      chk("midrst_reached", 32'(hit), 32'(1));
      chk("midrst_busy_before", 32'(busy), 32'(1));
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("midrst res_count", 32'(res_count), 32'(0));
      chk("midrst res_bits", 32'(res_bits), 32'(0));
      chk("midrst res_valid", 32'(res_valid), 32'(0));
      chk("midrst mux_a", 32'(mux_a), 32'(0));
      chk("midrst mux_d", 32'(mux_d), 32'(0));
      chk("midrst busy", 32'(busy), 32'(0));
      chk("midrst in_ready", 32'(in_ready), 32'(1));
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); @(negedge clk);
        if (res_valid || mux_a || mux_d != 2'b00 || busy || res_count != 0) bad++;
      end
      chk("midrst_entries_discarded", 32'(bad), 32'(0));
    end

    // ---- self-check: forced-low Y while driving (1,10) ----
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    force_y0 = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 2'b10;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("selfchk drive mux_a", 32'(mux_a), 32'(1));
    @(posedge clk); @(negedge clk);
    chk("selfchk forced res_bits", 32'(res_bits), 32'(8'h00));
    chk("selfchk forced res_count", 32'(res_count), 32'(1));
    chk("selfchk err set", 32'(err), 32'(SELF_CHECK));
    force_y0 = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 2'b10;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("selfchk good res_bits", 32'(res_bits), 32'(8'h01));
    chk("selfchk err sticky", 32'(err), 32'(SELF_CHECK));
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    chk("selfchk err cleared", 32'(err), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
